mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter that shares the processor's single data/instruction memory between the CPU control FSM (requester 0) and the program loader / debug port (requester 1). Each requester gets a req/ack handshake. The arbiter serialises accesses with round-robin priority and drives the one synchronous memory port. It sits between the control unit's memory-enable outputs and the memory array. The CPU FSM holds its current state until `cpu_ack` arrives.

## Interface
- `ADDR_W`, default 10: word-address width of the memory.
- `DATA_W`, default 32: data word width.
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-high; clears all state immediately.
- `cpu_req` input 1: CPU access request; held with `cpu_we`, `cpu_addr` and `cpu_wdata` stable until `cpu_ack`.
- `cpu_we` input 1: 1 = write, 0 = read.
- `cpu_addr` input `ADDR_W`: word address.
- `cpu_wdata` input `DATA_W`: write data.
- `cpu_rdata` output `DATA_W`: read data, valid in the `cpu_ack` cycle.
- `cpu_ack` output 1: one-cycle completion pulse.
- `ldr_req`, `ldr_we`, `ldr_addr`, `ldr_wdata`, `ldr_rdata`, `ldr_ack`: same directions, widths and meanings, for the loader.
- `mem_en` output 1: memory access strobe.
- `mem_we` output 1: memory write enable; only meaningful with `mem_en`.
- `mem_addr` output `ADDR_W`: memory address.
- `mem_wdata` output `DATA_W`: memory write data.
- `mem_rdata` input `DATA_W`: synchronous read data, valid the cycle after `mem_en`.
- `busy` output 1: high in any state other than IDLE.
- `owner` output 1: port of the current or most recent grant (0 = cpu, 1 = ldr).

## Operation
- **States:** IDLE, ISSUE, RESP (3-state FSM). Encoding is free.
- **IDLE:**
  - No request: stay in IDLE.
  - Exactly one `*_req` high: grant that port.
  - Both high: grant the port that is not `last`. `last` is a 1-bit register naming the last-served port.
  - On grant: latch `we`, `addr` and `wdata` of the granted port into the `mem_*` output registers, set `owner`, go to ISSUE.
- **ISSUE:** `mem_en` = 1, with `mem_we`, `mem_addr` and `mem_wdata` from the latched values. Go to RESP unconditionally.
- **RESP:**
  - `mem_en` = 0. Granted port's `*_ack` = 1 for exactly this cycle. `last` ← `owner`. Go to IDLE.
  - Read: granted port's `*_rdata` shows `mem_rdata` during RESP (bypass) and is captured into that port's rdata register at the end of RESP.
  - Write: `*_rdata` unchanged.
- **rdata hold:** each port's rdata register holds its value until that port's next read completes. The other port's completions never change it.
- **Request signals outside IDLE:** requests and request-side inputs are ignored in ISSUE and RESP. Latched values are used, so changing inputs after grant has no effect.
- **req held after ack:** a `*_req` still high in the IDLE cycle after its ack is a new transaction. The requester drops `req` in the cycle after ack if it does not want another access.
- **Starvation bound:** with both ports requesting continuously, grants alternate, so each port waits at most one transaction (3 cycles) before its grant.
- **Reset values:**
  - `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`, both acks, both rdata registers, `busy`, `owner`: all 0.
  - State = IDLE; `last` = 1, so the CPU wins the first tie.
- **Reset mid-operation:** FSM returns to IDLE and `mem_en` clears asynchronously. No ack is issued for the abandoned access. A write is performed only if `mem_en` was high at a rising clock edge with `reset` low.

## Timing
- **Read or write latency:** request sampled in IDLE at cycle N → `mem_en` in cycle N+1 → ack (and read data) in cycle N+2. Back in IDLE at N+3.
- **Throughput:** at most one access per 3 cycles total, shared across both ports.
- **Registered outputs:** `mem_*`, `owner` and `last`.
- **Combinational outputs:** `*_ack` and `busy` are decoded from state. `*_rdata` is decoded from state plus `mem_rdata` in RESP.
- **Memory contract:** single port, read-before-write not required. Read data appears one cycle after `mem_en`.

## Test plan
- **Single CPU read:** after reset, `cpu_req`=1, `cpu_we`=0, `cpu_addr`=0x005, mem[5]=0xDEADBEEF → `mem_en` at cycle 1 with `mem_addr`=0x005; `cpu_ack` at cycle 2 with `cpu_rdata`=0xDEADBEEF; `ldr_ack` never asserts.
- **Loader write then CPU read:**
  - `ldr_req` write of 0x12345678 to 0x010 → `mem_we`=1, `mem_addr`=0x010 in ISSUE; `ldr_ack` pulses once.
  - Then a CPU read of 0x010 → `cpu_rdata`=0x12345678; `ldr_rdata` unchanged (0).
- **Simultaneous requests from reset:** both `req` high continuously for 12 cycles → grant order cpu, ldr, cpu, ldr; acks at cycles 2, 5, 8, 11; `owner` toggles accordingly.
- **Input change after grant:** CPU read of 0x001 granted, then `cpu_addr` changes to 0x002 during ISSUE → `mem_addr` stays 0x001; returned data is mem[1].
- **Reset mid-operation:** assert `reset` during ISSUE of a loader write → `mem_en`=0 immediately; no `ldr_ack`; memory location unchanged; after release, `busy`=0 and the first tie goes to the CPU.
- **rdata hold:** CPU read returns 0xA5A5A5A5, then the loader reads 0x0F0F0F0F → `cpu_rdata` remains 0xA5A5A5A5.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous memory port between the CPU FSM
// (port 0) and the program loader (port 1); each access is IDLE -> ISSUE -> RESP.
module mem_arbiter #(
   parameter int ADDR_W = 10,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_req,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_wdata,
   output logic [DATA_W-1:0] cpu_rdata,
   output logic              cpu_ack,
   input  logic              ldr_req,
   input  logic              ldr_we,
   input  logic [ADDR_W-1:0] ldr_addr,
   input  logic [DATA_W-1:0] ldr_wdata,
   output logic [DATA_W-1:0] ldr_rdata,
   output logic              ldr_ack,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy,
   output logic              owner
);

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

   state_t              state_q, state_d;
   logic                mem_en_q, mem_en_d;
   logic                mem_we_q, mem_we_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                owner_q, owner_d;
   logic                last_q, last_d;
   logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
   logic [DATA_W-1:0]   ldr_rdata_q, ldr_rdata_d;
   logic                take_ldr;

   // On a tie the loader wins only if the CPU was served last.
   assign take_ldr = ldr_req && (!cpu_req || !last_q);

   always_comb begin
      // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
      state_d     = state_q;
      mem_en_d    = 1'b0;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      owner_d     = owner_q;
      last_d      = last_q;
      cpu_rdata_d = cpu_rdata_q;
      ldr_rdata_d = ldr_rdata_q;
      unique case (state_q)
         IDLE: begin
            if (cpu_req || ldr_req) begin
               state_d     = ISSUE;
               mem_en_d    = 1'b1;
               owner_d     = take_ldr;
               mem_we_d    = take_ldr ? ldr_we    : cpu_we;
               mem_addr_d  = take_ldr ? ldr_addr  : cpu_addr;
               mem_wdata_d = take_ldr ? ldr_wdata : cpu_wdata;
            end
         end
         ISSUE: state_d = RESP;
         RESP: begin
            state_d = IDLE;
            last_d  = owner_q;
            if (!mem_we_q) begin
               if (owner_q) ldr_rdata_d = mem_rdata;
               else         cpu_rdata_d = mem_rdata;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         mem_en_q    <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         owner_q     <= 1'b0;
         last_q      <= 1'b1;
         cpu_rdata_q <= '0;
         ldr_rdata_q <= '0;
      end else begin
         state_q     <= state_d;
         mem_en_q    <= mem_en_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         owner_q     <= owner_d;
         last_q      <= last_d;
         cpu_rdata_q <= cpu_rdata_d;
         ldr_rdata_q <= ldr_rdata_d;
      end
   end

   assign mem_en    = mem_en_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign owner     = owner_q;
   assign busy      = (state_q != IDLE);
   assign cpu_ack   = (state_q == RESP) && !owner_q;
   assign ldr_ack   = (state_q == RESP) &&  owner_q;

   // Read data bypasses straight from the memory during the ack cycle.
   assign cpu_rdata = (cpu_ack && !mem_we_q) ? mem_rdata : cpu_rdata_q;
   assign ldr_rdata = (ldr_ack && !mem_we_q) ? mem_rdata : ldr_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic,
// compared every cycle against a transaction-level model and a reference memory.
module tb_mem_arbiter;

   localparam int AW = 10;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          reset;
   logic          cpu_req = 1'b0, cpu_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [DW-1:0] cpu_wdata = '0;
   logic [DW-1:0] cpu_rdata;
   logic          cpu_ack;
   logic          ldr_req = 1'b0, ldr_we = 1'b0;
   logic [AW-1:0] ldr_addr = '0;
   logic [DW-1:0] ldr_wdata = '0;
   logic [DW-1:0] ldr_rdata;
   logic          ldr_ack;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   logic          busy, owner;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack),
      .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
      .ldr_rdata(ldr_rdata), .ldr_ack(ldr_ack),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;
   bit chk_on   = 1'b0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end else begin
         n_pass++;
      end
   endtask

   function automatic logic [DW-1:0] pat(input int a);
      case (a)
         5:       pat = 32'hDEADBEEF;
         1:       pat = 32'h11111111;
         2:       pat = 32'h22222222;
         'h20:    pat = 32'h00000055;
         'h30:    pat = 32'hA5A5A5A5;
         'h31:    pat = 32'h0F0F0F0F;
         default: pat = 32'(a) * 32'h9E3779B1;
      endcase
   endfunction

   // Memory device attached to the DUT's memory port
   logic [DW-1:0] dev_mem [1024];
   always @(posedge clk) begin
      if (mem_en) begin
         if (mem_we) dev_mem[mem_addr] <= mem_wdata;
         mem_rdata <= dev_mem[mem_addr];
      end
   end

   // Reference model: one outstanding transaction with a cycles-left countdown
   // (2 = memory strobe cycle, 1 = ack cycle, 0 = none) and its own memory image.
   typedef struct packed {
      logic          we;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } txn_t;

   logic [DW-1:0] ref_mem [1024];
   txn_t          cur;
   int            left;
   logic          m_owner, m_last;
   logic [DW-1:0] m_rd [2];

   initial begin
      for (int i = 0; i < 1024; i++) begin
         dev_mem[i] <= pat(i);
         ref_mem[i] = pat(i);
      end
   end

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         left    = 0;
         cur     = '0;
         m_owner = 1'b0;
         m_last  = 1'b1;
         m_rd[0] = '0;
         m_rd[1] = '0;
      end else if (left == 0) begin
         if (cpu_req || ldr_req) begin
            m_owner = (cpu_req && ldr_req) ? !m_last : ldr_req;
            cur     = m_owner ? '{ldr_we, ldr_addr, ldr_wdata} : '{cpu_we, cpu_addr, cpu_wdata};
            left    = 2;
         end
      end else if (left == 2) begin
         if (cur.we) ref_mem[cur.addr] = cur.wdata;
         left = 1;
      end else begin
         if (!cur.we) m_rd[m_owner] = ref_mem[cur.addr];
         m_last = m_owner;
         left   = 0;
      end
   end

   function automatic logic [DW-1:0] exp_rdata(input logic p);
      if (left == 1 && m_owner == p && !cur.we) exp_rdata = ref_mem[cur.addr];
      else                                      exp_rdata = m_rd[p];
   endfunction

   always @(negedge clk) begin
      if (chk_on) begin
         check("mem_en",    mem_en,    left == 2);
         check("mem_we",    mem_we,    cur.we);
         check("mem_addr",  mem_addr,  cur.addr);
         check("mem_wdata", mem_wdata, cur.wdata);
         check("busy",      busy,      left != 0);
         check("owner",     owner,     m_owner);
         check("cpu_ack",   cpu_ack,   left == 1 && !m_owner);
         check("ldr_ack",   ldr_ack,   left == 1 &&  m_owner);
         check("cpu_rdata", cpu_rdata, exp_rdata(1'b0));
         check("ldr_rdata", ldr_rdata, exp_rdata(1'b1));
      end
   end

   int cpu_ack_cnt = 0;
   int ldr_ack_cnt = 0;
   always @(negedge clk) begin
      if (cpu_ack) cpu_ack_cnt++;
      if (ldr_ack) ldr_ack_cnt++;
   end

   task automatic drive(input logic p, input logic rq, input logic we,
                        input logic [AW-1:0] a, input logic [DW-1:0] wd);
      if (p) begin ldr_req = rq; ldr_we = we; ldr_addr = a; ldr_wdata = wd; end
      else   begin cpu_req = rq; cpu_we = we; cpu_addr = a; cpu_wdata = wd; end
   endtask

   // Starts at a negedge, returns at the negedge of the ack cycle with req dropped.
   task automatic access(input logic p, input logic we, input logic [AW-1:0] a,
                         input logic [DW-1:0] wd, output logic [DW-1:0] rd, output int lat);
      bit got;
      got = 1'b0;
      rd  = 'x;
      lat = 0;
      drive(p, 1'b1, we, a, wd);
      for (int i = 0; i < 8 && !got; i++) begin
         @(negedge clk);
         lat++;
         if (p ? ldr_ack : cpu_ack) begin
            got = 1'b1;
            rd  = p ? ldr_rdata : cpu_rdata;
         end
      end
      drive(p, 1'b0, 1'b0, '0, '0);
   endtask

   // Releases reset 2 time units after a negedge; the caller drives cycle 0 next.
   task automatic do_reset();
      @(negedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      #2 reset = 1'b0;
   endtask

   logic [DW-1:0] rd;
   int            lat, cnt0;
   logic [11:0]   cpu_v, ldr_v, own_v;
   bit            act [2];
   int            waited [2];

   initial begin
      reset = 1'b0;
      #1 reset = 1'b1;
      chk_on = 1'b1;

      // Single CPU read after reset
      do_reset();
      drive(1'b0, 1'b1, 1'b0, 10'h005, '0);
      @(negedge clk);
      check("t1_mem_en", mem_en, 1'b1);
      check("t1_mem_addr", mem_addr, 10'h005);
      @(negedge clk);
      check("t1_cpu_ack", cpu_ack, 1'b1);
      check("t1_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      check("t1_idle", busy, 1'b0);
      check("t1_no_ldr_ack", ldr_ack_cnt, 0);

      // Loader write then CPU read of the same word
      cnt0 = ldr_ack_cnt;
      drive(1'b1, 1'b1, 1'b1, 10'h010, 32'h12345678);
      @(negedge clk);
      check("t2_mem_we", mem_we, 1'b1);
      check("t2_mem_addr", mem_addr, 10'h010);
      check("t2_mem_wdata", mem_wdata, 32'h12345678);
      @(negedge clk);
      check("t2_ldr_ack", ldr_ack, 1'b1);
      drive(1'b1, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      check("t2_ldr_ack_once", ldr_ack_cnt - cnt0, 1);
      access(1'b0, 1'b0, 10'h010, '0, rd, lat);
      check("t2_cpu_lat", lat, 2);
      check("t2_cpu_rdata", rd, 32'h12345678);
      check("t2_ldr_rdata", ldr_rdata, 32'h0);
      @(negedge clk);

      // Both requesting continuously from reset
      do_reset();
      drive(1'b0, 1'b1, 1'b0, 10'h001, '0);
      drive(1'b1, 1'b1, 1'b0, 10'h002, '0);
      cpu_v = '0; ldr_v = '0; own_v = '0;
      for (int c = 1; c < 12; c++) begin
         @(negedge clk);
         cpu_v[c] = cpu_ack;
         ldr_v[c] = ldr_ack;
         own_v[c] = owner;
      end
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      drive(1'b1, 1'b0, 1'b0, '0, '0);
      check("t3_cpu_acks", cpu_v, 12'h104);
      check("t3_ldr_acks", ldr_v, 12'h820);
      check("t3_owner", own_v, 12'hC70);
      @(negedge clk);

      // Request inputs change after the grant
      drive(1'b0, 1'b1, 1'b0, 10'h001, '0);
      @(negedge clk);
      check("t4_mem_addr", mem_addr, 10'h001);
      cpu_addr = 10'h002;
      @(negedge clk);
      check("t4_cpu_ack", cpu_ack, 1'b1);
      check("t4_cpu_rdata", cpu_rdata, 32'h11111111);
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      @(negedge clk);

      // Reset during the memory strobe of a loader write
      cnt0 = ldr_ack_cnt;
      drive(1'b1, 1'b1, 1'b1, 10'h020, 32'h0BADF00D);
      @(negedge clk);
      check("t5_mem_en_before", mem_en, 1'b1);
      #2 reset = 1'b1;
      #1;
      check("t5_mem_en_async", mem_en, 1'b0);
      check("t5_busy_async", busy, 1'b0);
      drive(1'b1, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      @(negedge clk);
      #2 reset = 1'b0;
      drive(1'b0, 1'b1, 1'b0, 10'h001, '0);
      drive(1'b1, 1'b1, 1'b0, 10'h002, '0);
      @(negedge clk);
      @(negedge clk);
      check("t5_tie_cpu_ack", cpu_ack, 1'b1);
      check("t5_tie_no_ldr_ack", ldr_ack, 1'b0);
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      repeat (3) @(negedge clk);
      check("t5_ldr_second", ldr_ack, 1'b1);
      drive(1'b1, 1'b0, 1'b0, '0, '0);
      @(negedge clk);
      check("t5_mem_unchanged", dev_mem[10'h020], 32'h00000055);
      check("t5_ldr_ack_count", ldr_ack_cnt - cnt0, 1);

      // Each port's read data holds across the other port's reads
      access(1'b0, 1'b0, 10'h030, '0, rd, lat);
      check("t6_cpu_rdata", rd, 32'hA5A5A5A5);
      access(1'b1, 1'b0, 10'h031, '0, rd, lat);
      check("t6_ldr_rdata", rd, 32'h0F0F0F0F);
      @(negedge clk);
      check("t6_cpu_hold", cpu_rdata, 32'hA5A5A5A5);

      // Random traffic from both ports
      act[0] = 1'b0; act[1] = 1'b0;
      waited[0] = 0; waited[1] = 0;
      for (int cyc = 0; cyc < 500; cyc++) begin
         @(negedge clk);
         for (int p = 0; p < 2; p++) begin
            if (act[p]) begin
               waited[p]++;
               if ((p == 1) ? ldr_ack : cpu_ack) begin
                  check("rnd_wait_bound", waited[p] <= 5, 1'b1);
                  if ($urandom_range(0, 3) == 0) begin
                     drive(1'(p), 1'b1, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), $urandom);
                     waited[p] = -1;
                  end else begin
                     drive(1'(p), 1'b0, 1'b0, '0, '0);
                     act[p] = 1'b0;
                  end
               end else if (waited[p] > 10) begin
                  check("rnd_ack_timeout", waited[p], 5);
                  drive(1'(p), 1'b0, 1'b0, '0, '0);
                  act[p] = 1'b0;
               end
            end else if ($urandom_range(0, 2) == 0) begin
               drive(1'(p), 1'b1, 1'($urandom_range(0, 1)), 10'($urandom_range(0, 15)), $urandom);
               act[p]    = 1'b1;
               waited[p] = 0;
            end
         end
      end
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      drive(1'b1, 1'b0, 1'b0, '0, '0);
      repeat (4) @(negedge clk);
      for (int a = 0; a < 16; a++) check("rnd_mem_image", dev_mem[a], ref_mem[a]);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
      $fatal(1);
   end

endmodule
